ud_dir_ctrl: RTL and testbench



---
 rtl/ud_pkg.sv | 12 +
 rtl/ud_debounce.sv | 42 ++++
 rtl/ud_dir_ctrl.sv | 90 +++++++++
 tb/tb_ud_dir_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ud_pkg.sv
// Shared types for the up/down direction controller: FSM state encoding
// (doubles as the mode output) and the default counter width.
package ud_pkg;
    localparam int UD_CNT_W = 5;

    typedef enum logic [1:0] {
        MAN_UP    = 2'b00,
        MAN_DOWN  = 2'b01,
        AUTO_UP   = 2'b10,
        AUTO_DOWN = 2'b11
    } ud_state_t;
endpackage

// File: rtl/ud_debounce.sv
// Button conditioner: 2-flop synchronizer, DB_CYCLES-sample debouncer and a
// one-cycle press pulse registered together with the debounced rising edge.
module ud_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // DB_CYCLES-th consecutive differing sample: accept the new level
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ud_dir_ctrl.sv
// Direction controller for the up_down counter: debounced buttons pick the direction;
// with UD_AUTO_BOUNCE_EN defined, auto mode reverses at CNT_MAX-1 / CNT_MIN+1 feedback.
module ud_dir_ctrl
    import ud_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = UD_CNT_W,
    parameter int CNT_MAX   = 31,
    parameter int CNT_MIN   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             auto_en,
    input  logic [CNT_W-1:0] count,
    output logic             up_down,
    output logic [1:0]       mode,
    output logic             dir_flip
);
    logic      press_up;
    logic      press_down;
    ud_state_t state;
    ud_state_t next;

    ud_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_up),
        .press (press_up)
    );

    ud_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_down),
        .press (press_down)
    );

`ifdef UD_AUTO_BOUNCE_EN
    // Flip one step early so the counter's next step lands on the limit itself.
    localparam logic [CNT_W-1:0] FLIP_HI = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] FLIP_LO = CNT_W'(CNT_MIN + 1);

    always_comb begin
        next = state;
        if (press_up && press_down) begin
            next = state;
        end else if (press_up) begin
            next = auto_en ? AUTO_UP : MAN_UP;
        end else if (press_down) begin
            next = auto_en ? AUTO_DOWN : MAN_DOWN;
        end else if (state[1] && !auto_en) begin
            next = ud_state_t'({1'b0, state[0]});
        end else if (!state[1] && auto_en) begin
            next = ud_state_t'({1'b1, state[0]});
        end else if (state == AUTO_UP && count >= FLIP_HI) begin
            next = AUTO_DOWN;
        end else if (state == AUTO_DOWN && count <= FLIP_LO) begin
            next = AUTO_UP;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = ^{auto_en, count};

    always_comb begin
        next = state;
        if (press_up && !press_down) begin
            next = MAN_UP;
        end else if (press_down && !press_up) begin
            next = MAN_DOWN;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MAN_UP;
            up_down  <= 1'b1;
            dir_flip <= 1'b0;
        end else begin
            state    <= next;
            up_down  <= ~next[0];
            dir_flip <= (~next[0]) != up_down;
        end
    end

    assign mode = state;
endmodule

// File: tb/tb_ud_dir_ctrl.sv
// Directed bench for ud_dir_ctrl (DB_CYCLES=4) with a behavioural 5-bit up/down counter
// model closing the count feedback loop.
module tb_ud_dir_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       auto_en;
    logic [4:0] count;
    logic       up_down;
    logic [1:0] mode;
    logic       dir_flip;

    int errors = 0;
    int checks = 0;
    bit cnt_run = 1'b0;

    typedef struct {
        logic       bu;
        logic       bd;
        logic       ae;
        int         n;
        logic       ud;
        logic [1:0] md;
        logic       fl;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    ud_dir_ctrl #(
        .DB_CYCLES (4),
        .CNT_W     (5),
        .CNT_MAX   (31),
        .CNT_MIN   (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .auto_en  (auto_en),
        .count    (count),
        .up_down  (up_down),
        .mode     (mode),
        .dir_flip (dir_flip)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ud, input logic [1:0] md, input logic fl);
        check({tag, ".up_down"}, {7'd0, up_down}, {7'd0, ud});
        check({tag, ".mode"}, {6'd0, mode}, {6'd0, md});
        check({tag, ".dir_flip"}, {7'd0, dir_flip}, {7'd0, fl});
    endtask

    // One clock edge; the counter model steps with the direction seen before the edge.
    task automatic tick();
        logic [4:0] nxt;
        nxt = up_down ? count + 5'd1 : count - 5'd1;
        @(posedge clk);
        #1;
        if (cnt_run) count = nxt;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 6,  1'b1, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1,  1'b0, 2'b01, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3,  1'b0, 2'b01, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8,  1'b0, 2'b01, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 3,  1'b0, 2'b01, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8,  1'b0, 2'b01, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 6,  1'b0, 2'b01, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1,  1'b1, 2'b00, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 2'b00, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8,  1'b1, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 10, 1'b1, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8,  1'b1, 2'b00, 1'b0};

        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        auto_en  = 1'b0;
        count    = 5'd0;
        #1;
        check_out("rst_async", 1'b1, 2'b00, 1'b0);
        tick();
        tick();
        check_out("rst_held", 1'b1, 2'b00, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("rst_rel%0d", k), 1'b1, 2'b00, 1'b0);
        end

        // Table: press down, release, short up pulse, long up press, simultaneous press.
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                btn_up   = vecs[i].bu;
                btn_down = vecs[i].bd;
                auto_en  = vecs[i].ae;
                tick();
                check_out($sformatf("vec%0d_%0d", i, k), vecs[i].ud, vecs[i].md, vecs[i].fl);
            end
        end

        // Reset clears outputs without a clock edge, even while dir_flip is high.
        btn_down = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_out("arst_pre", 1'b1, 2'b00, 1'b0);
        tick();
        check_out("arst_flip", 1'b0, 2'b01, 1'b1);
        #3;
        reset    = 1'b1;
        btn_down = 1'b0;
        #1;
        check_out("arst_now", 1'b1, 2'b00, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out($sformatf("arst_after%0d", k), 1'b1, 2'b00, 1'b0);
        end

        // Reset 2 cycles into a down press: the press must be lost.
        btn_down = 1'b1;
        tick();
        tick();
        reset    = 1'b1;
        btn_down = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_out($sformatf("middb%0d", k), 1'b1, 2'b00, 1'b0);
        end

`ifdef UD_AUTO_BOUNCE_EN
        begin
            int         flips;
            logic [4:0] prev;
            logic [4:0] cmax;
            logic [4:0] cmin;
            logic       wrap;
            auto_en = 1'b1;
            tick();
            check_out("auto_enter", 1'b1, 2'b10, 1'b0);
            btn_up = 1'b1;
            for (int k = 0; k < 7; k++) begin
                tick();
                check_out($sformatf("auto_press%0d", k), 1'b1, 2'b10, 1'b0);
            end
            btn_up = 1'b0;
            for (int k = 0; k < 8; k++) tick();
            flips = 0;
            cmax  = 5'd0;
            cmin  = 5'd31;
            prev  = count;
            cnt_run = 1'b1;
            for (int k = 0; k < 80; k++) begin
                tick();
                if (dir_flip) flips++;
                if (count > cmax) cmax = count;
                if (count < cmin) cmin = count;
                wrap = (prev == 5'd31 && count == 5'd0) || (prev == 5'd0 && count == 5'd31);
                check($sformatf("nowrap%0d", k), {7'd0, wrap}, 8'd0);
                check($sformatf("automode%0d", k), {7'd0, mode[1]}, 8'd1);
                if (count == 5'd31) check($sformatf("ud_at_max%0d", k), {7'd0, up_down}, 8'd0);
                if (count == 5'd0)  check($sformatf("ud_at_min%0d", k), {7'd0, up_down}, 8'd1);
                prev = count;
            end
            cnt_run = 1'b0;
            check("bounce_max", {3'd0, cmax}, 8'd31);
            check("bounce_min", {3'd0, cmin}, 8'd0);
            check("bounce_flips", 8'(flips), 8'd2);
            auto_en = 1'b0;
            tick();
            check_out("auto_exit", 1'b1, 2'b00, 1'b0);
        end
`else
        auto_en = 1'b1;
        cnt_run = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check_out($sformatf("noauto%0d", k), 1'b1, 2'b00, 1'b0);
        end
        btn_down = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_out($sformatf("noauto_pre%0d", k), 1'b1, 2'b00, 1'b0);
        end
        tick();
        check_out("noauto_flip", 1'b0, 2'b01, 1'b1);
        btn_down = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out($sformatf("noauto_post%0d", k), 1'b0, 2'b01, 1'b0);
        end
        cnt_run = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
